// File: rtl/if_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package if_pkg;
    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [ILEN-1:0] inst;
    } qent_t;
endpackage

// File: rtl/if_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer and memory.
interface if_ctrl_if;
    import if_pkg::*;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [ILEN-1:0] imem_rdata_i;

    modport master (output imem_req_o, imem_addr_o,
                    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i);
    modport slave  (input  imem_req_o, imem_addr_o,
                    output imem_gnt_i, imem_rvalid_i, imem_rdata_i);
endinterface

// File: rtl/if_ctrl_inst_fifo.sv
// Small synchronous instruction queue; clear wins over push/pop in the same cycle.
module inst_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  qent_t         data_i,
    input  logic          pop_i,
    input  logic          clr_i,
    output logic [CW-1:0] count_o,
    output qent_t         head_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    qent_t         mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop_i & (cnt_q != '0);
    assign do_push = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clr_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= nxt(wr_q);
            end
            if (do_pop) rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/if_ctrl.sv
// Fetch sequencer: owns the PC, keeps one request in flight, queues responses for decode.
module if_ctrl
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            trap_en_i,
    input  logic [XLEN-1:0] trap_addr_i,
    if_ctrl_if.master       imem,
    output logic            inst_valid_o,
    output logic [ILEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_addr_o,
    input  logic            inst_ready_i,
    output logic            flush_o
);
    localparam int CW = $clog2(QDEPTH + 1);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, infl_q, infl_d;
    logic            out_q, out_d;
    logic            redirect, rsp, gnt, credit_ok, push, clr, pop;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   q_cnt;
    logic [CW:0]     used;
    qent_t           head;

    assign redirect  = trap_en_i | jump_en_i;
    assign target    = trap_en_i ? trap_addr_i : jump_addr_i;
    assign rsp       = imem.imem_rvalid_i & out_q;
    assign used      = {1'b0, q_cnt} + (CW + 1)'(out_q);
    assign credit_ok = used < (CW + 1)'(QDEPTH);

    // Redirect kills the request combinationally; memory tolerates withdrawal.
    assign imem.imem_req_o  = rst & ~redirect & (state_q == RUN)
                            & (~out_q | imem.imem_rvalid_i) & credit_ok;
    assign imem.imem_addr_o = pc_q;
    assign gnt              = imem.imem_req_o & imem.imem_gnt_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        out_d   = out_q;
        infl_d  = infl_q;
        push    = 1'b0;
        clr     = 1'b0;
        if (rsp) begin
            out_d   = 1'b0;
            push    = (state_q == RUN) & ~redirect;
            state_d = RUN;
        end
        if (gnt) begin
            pc_d   = pc_q + 32'd4;
            out_d  = 1'b1;
            infl_d = pc_q;
        end
        if (redirect) begin
            pc_d = target;
            clr  = 1'b1;
            // Response still owed by memory: remember to discard it.
            if (out_q & ~imem.imem_rvalid_i) state_d = DRAIN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            out_q   <= 1'b0;
            infl_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            infl_q  <= infl_d;
        end
    end

    assign pop     = inst_valid_o & inst_ready_i;
    assign flush_o = rst & redirect;

    inst_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ('{addr: infl_q, inst: imem.imem_rdata_i}),
        .pop_i   (pop),
        .clr_i   (clr),
        .count_o (q_cnt),
        .head_o  (head)
    );

    assign inst_valid_o = q_cnt != '0;
    assign inst_o       = head.inst;
    assign inst_addr_o  = head.addr;
endmodule

// File: tb/tb_if_ctrl.sv
// Directed per-cycle vectors for the fetch sequencer; memory responses are scripted by hand.
module tb_if_ctrl;
    import if_pkg::*;

    typedef struct {
        logic        rst, jmp, trp, gnt, rv, rdy;
        logic [31:0] jaddr, taddr, rdata;
        logic        req, vld, flush;
        logic [31:0] addr, iaddr, inst;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_en = 1'b0, trap_en = 1'b0, inst_ready = 1'b1;
    logic [31:0] jump_addr = '0, trap_addr = '0;
    logic        inst_valid, flush;
    logic [31:0] inst, inst_addr;
    int          n_chk = 0, n_fail = 0;
    vec_t        tbl[$];

    always #5 clk = ~clk;

    if_ctrl_if imem();

    if_ctrl #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en_i    (jump_en),
        .jump_addr_i  (jump_addr),
        .trap_en_i    (trap_en),
        .trap_addr_i  (trap_addr),
        .imem         (imem),
        .inst_valid_o (inst_valid),
        .inst_o       (inst),
        .inst_addr_o  (inst_addr),
        .inst_ready_i (inst_ready),
        .flush_o      (flush)
    );

    function automatic vec_t V(input logic rs, jm, tr, gn, rv, rd,
                               input logic [31:0] ja, ta, rdat,
                               input logic eq, input logic [31:0] ea,
                               input logic ev, input logic [31:0] eia, ei,
                               input logic ef);
        vec_t v;
        v.rst = rs; v.jmp = jm; v.trp = tr; v.gnt = gn; v.rv = rv; v.rdy = rd;
        v.jaddr = ja; v.taddr = ta; v.rdata = rdat;
        v.req = eq; v.addr = ea; v.vld = ev; v.iaddr = eia; v.inst = ei; v.flush = ef;
        return v;
    endfunction

    // Plain running cycle: no reset, no redirect.
    function automatic vec_t N(input logic gn, rv, input logic [31:0] rdat, input logic rd,
                               input logic eq, input logic [31:0] ea,
                               input logic ev, input logic [31:0] eia, ei);
        return V(1, 0, 0, gn, rv, rd, 0, 0, rdat, eq, ea, ev, eia, ei, 0);
    endfunction

    function automatic vec_t RST(input logic gn);
        return V(0, 0, 0, gn, 0, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        rst = v.rst; jump_en = v.jmp; jump_addr = v.jaddr; trap_en = v.trp; trap_addr = v.taddr;
        imem.imem_gnt_i = v.gnt; imem.imem_rvalid_i = v.rv; imem.imem_rdata_i = v.rdata;
        inst_ready = v.rdy;
        #1;
        chk({nm, " req"},   32'(imem.imem_req_o), 32'(v.req));
        chk({nm, " addr"},  imem.imem_addr_o,     v.addr);
        chk({nm, " flush"}, 32'(flush),           32'(v.flush));
        chk({nm, " vld"},   32'(inst_valid),      32'(v.vld));
        if (v.vld || !v.rst) begin
            chk({nm, " iaddr"}, inst_addr, v.iaddr);
            chk({nm, " inst"},  inst,      v.inst);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        imem.imem_gnt_i = 1'b0; imem.imem_rvalid_i = 1'b0; imem.imem_rdata_i = '0;

        // Streaming with gnt always high and 1-cycle response latency.
        tbl.push_back(RST(1));
        tbl.push_back(N(1, 0, 0,            1, 1, 32'h0,  0, 0, 0));
        tbl.push_back(N(1, 1, 32'hD0000000, 1, 1, 32'h4,  0, 0, 0));
        tbl.push_back(N(1, 1, 32'hD0000004, 1, 0, 32'h8,  1, 32'h0, 32'hD0000000));
        tbl.push_back(N(1, 0, 0,            1, 1, 32'h8,  1, 32'h4, 32'hD0000004));
        tbl.push_back(N(1, 1, 32'hD0000008, 1, 1, 32'hC,  0, 0, 0));
        tbl.push_back(N(1, 1, 32'hD000000C, 1, 0, 32'h10, 1, 32'h8, 32'hD0000008));
        // Reset mid-stream, then decode stalled for 6 cycles.
        tbl.push_back(RST(1));
        tbl.push_back(N(1, 0, 0,            0, 1, 32'h0,  0, 0, 0));
        tbl.push_back(N(1, 1, 32'hD0000000, 0, 1, 32'h4,  0, 0, 0));
        tbl.push_back(N(1, 1, 32'hD0000004, 0, 0, 32'h8,  1, 32'h0, 32'hD0000000));
        for (int i = 0; i < 3; i++)
            tbl.push_back(N(1, 0, 0,        0, 0, 32'h8,  1, 32'h0, 32'hD0000000));
        tbl.push_back(N(1, 0, 0,            1, 0, 32'h8,  1, 32'h0, 32'hD0000000));
        tbl.push_back(N(1, 0, 0,            1, 1, 32'h8,  1, 32'h4, 32'hD0000004));
        tbl.push_back(N(1, 1, 32'hD0000008, 1, 1, 32'hC,  0, 0, 0));
        tbl.push_back(N(1, 1, 32'hD000000C, 1, 0, 32'h10, 1, 32'h8, 32'hD0000008));
        tbl.push_back(N(1, 0, 0,            1, 1, 32'h10, 1, 32'hC, 32'hD000000C));
        // Fill the queue, reset while full, stray rvalid afterwards.
        tbl.push_back(N(1, 1, 32'hD0000010, 0, 1, 32'h14, 0, 0, 0));
        tbl.push_back(N(1, 1, 32'hD0000014, 0, 0, 32'h18, 1, 32'h10, 32'hD0000010));
        tbl.push_back(N(1, 0, 0,            0, 0, 32'h18, 1, 32'h10, 32'hD0000010));
        tbl.push_back(RST(0));
        tbl.push_back(N(0, 1, 32'hDEADBEEF, 1, 1, 32'h0,  0, 0, 0));
        tbl.push_back(N(0, 0, 0,            1, 1, 32'h0,  0, 0, 0));
        tbl.push_back(N(0, 0, 0,            1, 1, 32'h0,  0, 0, 0));
        // Redirect while grant withheld, then PC wrap at the top of memory.
        tbl.push_back(V(1, 1, 0, 0, 0, 1, 32'h40, 0, 0, 0, 32'h0, 0, 0, 0, 1));
        tbl.push_back(N(1, 0, 0,            1, 1, 32'h40, 0, 0, 0));
        tbl.push_back(V(1, 1, 0, 1, 1, 1, 32'hFFFFFFFC, 0, 32'hD0000040, 0, 32'h44, 0, 0, 0, 1));
        tbl.push_back(N(1, 0, 0,            1, 1, 32'hFFFFFFFC, 0, 0, 0));
        tbl.push_back(N(0, 0, 0,            1, 0, 32'h0,  0, 0, 0));
        tbl.push_back(N(0, 1, 32'hDFFFFFFC, 1, 1, 32'h0,  0, 0, 0));
        tbl.push_back(N(0, 0, 0,            1, 1, 32'h0,  1, 32'hFFFFFFFC, 32'hDFFFFFFC));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Jump to 0x100 while the fetch of 0xC is still in flight.
        apply(RST(1), "j0");
        apply(N(1, 0, 0,            1, 1, 32'h0,  0, 0, 0), "j1");
        apply(N(1, 1, 32'hD0000000, 1, 1, 32'h4,  0, 0, 0), "j2");
        apply(N(1, 1, 32'hD0000004, 1, 0, 32'h8,  1, 32'h0, 32'hD0000000), "j3");
        apply(N(1, 0, 0,            1, 1, 32'h8,  1, 32'h4, 32'hD0000004), "j4");
        apply(N(1, 1, 32'hD0000008, 1, 1, 32'hC,  0, 0, 0), "j5");
        apply(V(1, 1, 0, 1, 0, 1, 32'h100, 0, 0, 0, 32'h10, 1, 32'h8, 32'hD0000008, 1), "j6");
        apply(N(1, 1, 32'hD000000C, 1, 0, 32'h100, 0, 0, 0), "j7");
        apply(N(1, 0, 0,            1, 1, 32'h100, 0, 0, 0), "j8");
        apply(N(1, 1, 32'hD0000100, 1, 1, 32'h104, 0, 0, 0), "j9");
        apply(N(1, 1, 32'hD0000104, 1, 0, 32'h108, 1, 32'h100, 32'hD0000100), "j10");
        apply(N(1, 0, 0,            1, 1, 32'h108, 1, 32'h104, 32'hD0000104), "j11");

        // Trap and jump together (trap wins), then a second jump during DRAIN.
        apply(V(1, 1, 1, 1, 0, 1, 32'h200, 32'h80, 0, 0, 32'h10C, 0, 0, 0, 1), "t0");
        apply(V(1, 1, 0, 1, 0, 1, 32'h300, 0, 0, 0, 32'h80, 0, 0, 0, 1), "t1");
        apply(N(1, 1, 32'hD0000108, 1, 0, 32'h300, 0, 0, 0), "t2");
        apply(N(1, 0, 0,            1, 1, 32'h300, 0, 0, 0), "t3");
        apply(N(1, 1, 32'hD0000300, 1, 1, 32'h304, 0, 0, 0), "t4");
        apply(N(1, 1, 32'hD0000304, 1, 0, 32'h308, 1, 32'h300, 32'hD0000300), "t5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
